// File: rtl/btn_pkg.sv
// Shared types for the button event scheduler.
// Holds the per-channel debounce state encoding and an id-width helper.
// No logic; imported by the channel and the top.
package btn_pkg;

    // Bit 1 of the encoding is the debounced level (HIGH and WAIT_LOW).
    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_WAIT_LOW  = 2'b11
    } ch_state_e;

    // Width of a channel index; never below one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_db_channel.sv
// One button channel: 2-flop synchroniser, 4-state stability FSM, down-counter.
// level follows a confirmed change; set_pend pulses on the tick that confirms a press.
// No backpressure: set_pend is a single-cycle strobe consumed by the top.
module btn_db_channel
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = 4000,
    parameter int CNT_W        = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic set_pend
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_TICKS - 1);

    // Refuse to build when the reload value cannot be held by the counter.
    if (STABLE_TICKS < 1 || 64'(STABLE_TICKS - 1) >= (64'd1 << CNT_W)) begin : g_param_check
        $error("btn_db_channel: STABLE_TICKS-1 does not fit in CNT_W bits");
    end

    logic      sync1_q, sync1_d;
    logic      sync2_q, sync2_d;
    ch_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic      s;

    assign sync1_d = raw;
    assign sync2_d = sync1_q;
    assign s       = sync2_q;

    // State register: synchroniser, FSM state and stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: the FSM only moves on sample ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                ST_LOW: begin
                    if (s) begin
                        state_d = ST_WAIT_HIGH;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!s)                  state_d = ST_LOW;
                    else if (cnt_q == '0)    state_d = ST_HIGH;
                    else                     cnt_d   = cnt_q - 1'b1;
                end
                ST_HIGH: begin
                    if (!s) begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_WAIT_LOW: begin
                    if (s)                   state_d = ST_HIGH;
                    else if (cnt_q == '0)    state_d = ST_LOW;
                    else                     cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = ST_LOW;
            endcase
        end
    end

    // Outputs: level is a decode of the registered state; press strobe on confirmation.
    always_comb begin
        level    = (state_q == ST_HIGH) || (state_q == ST_WAIT_LOW);
        set_pend = tick && (state_q == ST_WAIT_HIGH) && s && (cnt_q == '0);
    end

endmodule

// File: rtl/btn_event_scheduler.sv
// Debounces NUM_BTN buttons and serialises confirmed presses onto one event port.
// Latency: confirming tick T -> pending flag T+1 -> evt_valid T+2 when the port is idle.
// Backpressure: evt_valid/evt_id hold while !evt_ready; repeat presses merge and set evt_overflow.
module btn_event_scheduler
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 4000,
    parameter int CNT_W        = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BTN-1:0]         btn_raw,
    output logic [NUM_BTN-1:0]         db_level,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic                       evt_overflow,
    input  logic                       ovf_clr
);

    localparam int ID_W  = id_w(NUM_BTN);
    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    evt_id_q, evt_id_d;
    logic               evt_valid_q, evt_valid_d;
    logic               ovf_q, ovf_d;

    logic               tick;
    logic [NUM_BTN-1:0] set_pend;
    logic               load;
    logic               found;
    logic               grant;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    cand;
    logic               ovf_set;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_db_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .raw      (btn_raw[i]),
            .level    (db_level[i]),
            .set_pend (set_pend[i])
        );
    end

    assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

    // Shared sample-tick prescaler, wraps at TICK_DIV-1.
    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Round-robin pick: first pending channel scanning from rr.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            cand = ID_W'((int'(rr_q) + k) % NUM_BTN);
            if (!found && pend_q[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Pending flags, output register, pointer and sticky overflow.
    always_comb begin
        load    = !evt_valid_q || evt_ready;
        grant   = load && found;
        ovf_set = 1'b0;
        pend_d  = pend_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            // A fresh press wins over a grant on the same channel: the flag stays up.
            if (set_pend[i]) begin
                pend_d[i] = 1'b1;
                if (pend_q[i] && !(grant && gnt_idx == ID_W'(i)))
                    ovf_set = 1'b1;
            end else if (grant && gnt_idx == ID_W'(i)) begin
                pend_d[i] = 1'b0;
            end
        end
        evt_valid_d = load ? found : evt_valid_q;
        evt_id_d    = grant ? gnt_idx : evt_id_q;
        if (grant)
            rr_d = (gnt_idx == ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx + 1'b1;
        else
            rr_d = rr_q;
        ovf_d = ovf_set || (ovf_q && !ovf_clr);
    end

    // Top-level state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            pend_q      <= '0;
            rr_q        <= '0;
            evt_id_q    <= '0;
            evt_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            evt_id_q    <= evt_id_d;
            evt_valid_q <= evt_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid    = evt_valid_q;
    assign evt_id       = evt_id_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with NUM_BTN=4, TICK_DIV=4, STABLE_TICKS=3.
// Timing reference: cyc counts clock edges since reset release; sample ticks land on edges cyc%4==0.
// A press driven at cyc c (c%4==1) reaches db_level at c+15 and evt_valid at c+16.
module tb_btn_event_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] db_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_overflow;
    logic       ovf_clr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ev_id[$];
    int ev_cyc[$];

    btn_event_scheduler #(
        .NUM_BTN      (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .CNT_W        (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .db_level     (db_level),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every handshake that will complete on the coming rising edge.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            ev_id.push_back(int'(evt_id));
            ev_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic align();
        while (cyc % 4 != 1) cycles(1);
    endtask

    initial begin
        int c;
        int base;

        reset     = 1'b1;
        btn_raw   = 4'b0000;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_db_level",  32'(db_level),     32'h0);
        check("rst_evt_valid", 32'(evt_valid),    32'h0);
        check("rst_evt_id",    32'(evt_id),       32'h0);
        check("rst_overflow",  32'(evt_overflow), 32'h0);
        reset = 1'b0;
        cyc   = 0;

        // 1: channel 2 held for 20 ticks -> exactly one event
        align();
        c = cyc;
        btn_raw[2] = 1'b1;
        cycles(14);
        check("t1_db_before", 32'(db_level), 32'h0);
        cycles(1);
        check("t1_db_after", 32'(db_level), 32'h4);
        check("t1_valid_not_yet", 32'(evt_valid), 32'h0);
        cycles(1);
        check("t1_valid", 32'(evt_valid), 32'h1);
        check("t1_id", 32'(evt_id), 32'h2);
        cycles(1);
        check("t1_valid_drop", 32'(evt_valid), 32'h0);
        cycles(63);
        check("t1_ev_count", 32'(ev_id.size()), 32'd1);
        check("t1_ev_id", 32'(ev_id[0]), 32'd2);
        check("t1_ev_cyc", 32'(ev_cyc[0]), 32'(c + 16));
        btn_raw[2] = 1'b0;
        cycles(24);
        check("t1_release", 32'(db_level), 32'h0);

        // 2: channel 1 bouncing every 2 ticks never qualifies, then a hold does
        align();
        base = ev_id.size();
        for (int i = 0; i < 14; i++) begin
            btn_raw[1] = ~btn_raw[1];
            cycles(8);
            check("t2_bounce_db", 32'(db_level[1]), 32'h0);
        end
        cycles(8);
        check("t2_bounce_no_ev", 32'(ev_id.size()), 32'(base));
        align();
        btn_raw[1] = 1'b1;
        cycles(17);
        check("t2_hold_ev_count", 32'(ev_id.size()), 32'(base + 1));
        check("t2_hold_ev_id", 32'(ev_id[base]), 32'd1);
        btn_raw[1] = 1'b0;
        cycles(24);

        // 3a: rr=2, channels 0,1,3 together -> 3,0,1 back to back
        align();
        c = cyc;
        base = ev_id.size();
        btn_raw = 4'b1011;
        cycles(20);
        check("t3a_count", 32'(ev_id.size()), 32'(base + 3));
        check("t3a_id0", 32'(ev_id[base]),     32'd3);
        check("t3a_id1", 32'(ev_id[base + 1]), 32'd0);
        check("t3a_id2", 32'(ev_id[base + 2]), 32'd1);
        check("t3a_cyc0", 32'(ev_cyc[base]),     32'(c + 16));
        check("t3a_cyc2", 32'(ev_cyc[base + 2]), 32'(c + 18));
        btn_raw = 4'b0000;
        cycles(24);

        // channel 3 alone moves rr to 0
        align();
        base = ev_id.size();
        btn_raw = 4'b1000;
        cycles(20);
        check("t3_rr_ev_id", 32'(ev_id[base]), 32'd3);
        btn_raw = 4'b0000;
        cycles(24);

        // 3b: rr=0 -> 0,1,3
        align();
        c = cyc;
        base = ev_id.size();
        btn_raw = 4'b1011;
        cycles(20);
        check("t3b_count", 32'(ev_id.size()), 32'(base + 3));
        check("t3b_id0", 32'(ev_id[base]),     32'd0);
        check("t3b_id1", 32'(ev_id[base + 1]), 32'd1);
        check("t3b_id2", 32'(ev_id[base + 2]), 32'd3);
        check("t3b_cyc1", 32'(ev_cyc[base + 1]), 32'(c + 17));
        btn_raw = 4'b0000;
        cycles(24);

        // 4: stalled port, repeated presses on channel 0
        evt_ready = 1'b0;
        align();
        btn_raw[0] = 1'b1;
        cycles(16);
        check("t4_valid", 32'(evt_valid), 32'h1);
        check("t4_id", 32'(evt_id), 32'h0);
        btn_raw[0] = 1'b0;
        cycles(24);
        align();
        btn_raw[0] = 1'b1;
        cycles(17);
        check("t4_second_id_held", 32'(evt_id), 32'h0);
        check("t4_second_valid", 32'(evt_valid), 32'h1);
        check("t4_second_no_ovf", 32'(evt_overflow), 32'h0);
        btn_raw[0] = 1'b0;
        cycles(24);
        align();
        btn_raw[0] = 1'b1;
        cycles(17);
        check("t4_third_ovf", 32'(evt_overflow), 32'h1);
        check("t4_third_id_held", 32'(evt_id), 32'h0);
        btn_raw[0] = 1'b0;
        cycles(24);
        check("t4_ovf_sticky", 32'(evt_overflow), 32'h1);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        check("t4_ovf_cleared", 32'(evt_overflow), 32'h0);
        base = ev_id.size();
        evt_ready = 1'b1;
        cycles(8);
        check("t4_drain_count", 32'(ev_id.size()), 32'(base + 2));
        check("t4_drain_id0", 32'(ev_id[base]),     32'd0);
        check("t4_drain_id1", 32'(ev_id[base + 1]), 32'd0);

        // 5: reset with events queued and channel 3 mid-qualification
        evt_ready = 1'b0;
        align();
        btn_raw = 4'b0111;
        cycles(17);
        check("t5_pre_valid", 32'(evt_valid), 32'h1);
        check("t5_pre_id", 32'(evt_id), 32'h1);
        btn_raw = 4'b0000;
        cycles(24);
        align();
        btn_raw[3] = 1'b1;
        cycles(8);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(evt_valid), 32'h0);
        check("t5_rst_id", 32'(evt_id), 32'h0);
        check("t5_rst_db", 32'(db_level), 32'h0);
        check("t5_rst_ovf", 32'(evt_overflow), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        evt_ready = 1'b1;
        base = ev_id.size();
        cycles(4);
        check("t5_discarded", 32'(evt_valid), 32'h0);
        cycles(11);
        check("t5_db_before", 32'(db_level), 32'h0);
        cycles(1);
        check("t5_db_after", 32'(db_level), 32'h8);
        check("t5_valid_not_yet", 32'(evt_valid), 32'h0);
        cycles(1);
        check("t5_valid", 32'(evt_valid), 32'h1);
        check("t5_id", 32'(evt_id), 32'h3);
        cycles(8);
        check("t5_ev_count", 32'(ev_id.size()), 32'(base + 1));
        check("t5_ev_id", 32'(ev_id[base]), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
